// File: rtl/cdf_remap_if.sv
// cdf_remap_if
//   Memory-side bus of the CDF remap engine: pixel scratchpad read port,
//   CDF table read port and output memory write port.
//   master : the remap engine (drives addresses and the write port)
//   slave  : the memory side (returns read data one cycle after the address)
//
//   Pix_ReadAddress   16   pixel memory word address
//   Pix_ReadBus       128  16 pixels, pixel k in bits [8k+7:8k]
//   Cdf_ReadAddress   16   CDF memory word address
//   Cdf_ReadBus       128  CDF value in bits [19:0], upper bits ignored
//   WriteEnable       1    output memory write strobe
//   Output_MEMAddress 16   output memory word address
//   Output_MEMBus     128  16 remapped pixels, same packing as Pix_ReadBus
interface cdf_remap_if;
   logic [15:0]  Pix_ReadAddress;
   logic [127:0] Pix_ReadBus;
   logic [15:0]  Cdf_ReadAddress;
   logic [127:0] Cdf_ReadBus;
   logic         WriteEnable;
   logic [15:0]  Output_MEMAddress;
   logic [127:0] Output_MEMBus;

   modport master (
      output Pix_ReadAddress,
      input  Pix_ReadBus,
      output Cdf_ReadAddress,
      input  Cdf_ReadBus,
      output WriteEnable,
      output Output_MEMAddress,
      output Output_MEMBus
   );

   modport slave (
      input  Pix_ReadAddress,
      output Pix_ReadBus,
      input  Cdf_ReadAddress,
      output Cdf_ReadBus,
      input  WriteEnable,
      input  Output_MEMAddress,
      input  Output_MEMBus
   );
endinterface

// File: rtl/cdf_remap.sv
// cdf_remap
//   Histogram-equalisation remap engine. For every 16-pixel word in the
//   pixel scratchpad it looks up each pixel's CDF value, computes
//   (cdf - cdf_min) * 255 / (num_pixels - cdf_min) with an 8-step restoring
//   divider (truncating, saturating at 255, zero when the denominator is 0)
//   and writes the packed result word to the output memory.
//
//   clock     in   rising-edge clock
//   reset_n   in   synchronous active-low reset
//   start     in   single-cycle run request (taken only with cdf_valid)
//   cdf_valid in   CDF table and Cdf_Min are complete
//   Cdf_Min   in   minimum nonzero CDF value, sampled when a run starts
//   busy      out  high whenever the engine is not idle
//   done      out  one-cycle pulse at the end of a run
//   mem       bus  memory ports (see cdf_remap_if)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | waiting for start with cdf_valid
//   PIX_RD   | pixel word address on the bus
//   PIX_WAIT | pixel word returns, latched into the pixel register
//   CDF_RD   | CDF address of pixel[pix_idx] on the bus
//   CDF_WAIT | CDF value returns, numerator formed
//   DIV      | 8 restoring-division steps, quotient bit 7 down to 0
//   WRITE    | one-cycle write of the packed result word
//   DONE     | one-cycle done pulse
module cdf_remap #(
   parameter logic [15:0] PIX_BASE   = 16'h0000,
   parameter logic [15:0] CDF_BASE   = 16'h4000,
   parameter logic [15:0] OUT_BASE   = 16'h0000,
   parameter int unsigned NUM_WORDS  = 16384,
   parameter int unsigned NUM_PIXELS = 262144
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        cdf_valid,
   input  logic [19:0] Cdf_Min,
   output logic        busy,
   output logic        done,
   cdf_remap_if.master mem
);

   localparam logic [15:0] LAST_WORD  = 16'(NUM_WORDS - 1);
   localparam logic [19:0] NUM_PIX_20 = 20'(NUM_PIXELS);

   typedef enum logic [2:0] {
      IDLE, PIX_RD, PIX_WAIT, CDF_RD, CDF_WAIT, DIV, WRITE, DONE
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   word_idx_q, word_idx_d;
   logic [3:0]    pix_idx_q, pix_idx_d;
   logic [127:0]  pix_q, pix_d;
   logic [127:0]  res_q, res_d;
   logic [19:0]   cdf_min_q, cdf_min_d;
   logic [19:0]   den_q, den_d;
   logic [27:0]   rem_q, rem_d;
   logic [7:0]    quo_q, quo_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic          sat_q, sat_d;
   logic [15:0]   pix_addr_q, pix_addr_d;
   logic [15:0]   cdf_addr_q, cdf_addr_d;
   logic          we_q, we_d;
   logic [15:0]   out_addr_q, out_addr_d;
   logic [127:0]  out_bus_q, out_bus_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [19:0]   cdf_val;
   logic [19:0]   diff;
   logic [27:0]   num;
   logic [27:0]   den_shift;
   logic [7:0]    res_byte;

   // Only the low 20 bits of the CDF word carry data.
   logic unused_cdf_hi;
   assign unused_cdf_hi = ^mem.Cdf_ReadBus[127:20];

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      pix_idx_d  = pix_idx_q;
      pix_d      = pix_q;
      res_d      = res_q;
      cdf_min_d  = cdf_min_q;
      den_d      = den_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      bit_cnt_d  = bit_cnt_q;
      sat_d      = sat_q;
      pix_addr_d = pix_addr_q;
      cdf_addr_d = cdf_addr_q;
      out_addr_d = out_addr_q;
      out_bus_d  = out_bus_q;
      cdf_val    = mem.Cdf_ReadBus[19:0];
      diff       = '0;
      num        = '0;
      den_shift  = '0;
      res_byte   = '0;

      case (state_q)
         IDLE: begin
            if (start && cdf_valid) begin
               state_d    = PIX_RD;
               word_idx_d = '0;
               cdf_min_d  = Cdf_Min;
               den_d      = NUM_PIX_20 - Cdf_Min;
            end
         end
         PIX_RD: state_d = PIX_WAIT;
         PIX_WAIT: begin
            pix_d     = mem.Pix_ReadBus;
            pix_idx_d = '0;
            state_d   = CDF_RD;
         end
         CDF_RD: state_d = CDF_WAIT;
         CDF_WAIT: begin
            diff      = (cdf_val > cdf_min_q) ? (cdf_val - cdf_min_q) : 20'd0;
            num       = 28'(diff) * 28'd255;
            rem_d     = num;
            quo_d     = '0;
            bit_cnt_d = 3'd7;
            // Quotient of 256 or more cannot be represented in 8 bits.
            sat_d     = (num >= {den_q, 8'h00});
            state_d   = DIV;
         end
         DIV: begin
            den_shift = {8'h00, den_q} << bit_cnt_q;
            if (rem_q >= den_shift) begin
               rem_d = rem_q - den_shift;
               quo_d = quo_q | (8'd1 << bit_cnt_q);
            end
            if (bit_cnt_q == 3'd0) begin
               if (den_q == 20'd0)
                  res_byte = 8'h00;
               else if (sat_q)
                  res_byte = 8'hFF;
               else
                  res_byte = quo_d;
               res_d[{pix_idx_q, 3'b000} +: 8] = res_byte;
               if (pix_idx_q == 4'd15) begin
                  state_d = WRITE;
               end else begin
                  pix_idx_d = pix_idx_q + 4'd1;
                  state_d   = CDF_RD;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - 3'd1;
            end
         end
         WRITE: begin
            if (word_idx_q == LAST_WORD) begin
               state_d = DONE;
            end else begin
               word_idx_d = word_idx_q + 16'd1;
               state_d    = PIX_RD;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered and set up on the edge entering their state,
      // so each strobe/address is visible during that state's own cycle.
      if (state_d == PIX_RD)
         pix_addr_d = PIX_BASE + word_idx_d;
      if (state_d == CDF_RD)
         cdf_addr_d = CDF_BASE + {8'h00, pix_d[{pix_idx_d, 3'b000} +: 8]};
      we_d = (state_d == WRITE);
      if (state_d == WRITE) begin
         out_addr_d = OUT_BASE + word_idx_q;
         out_bus_d  = res_d;
      end
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         word_idx_q <= '0;
         pix_idx_q  <= '0;
         pix_q      <= '0;
         res_q      <= '0;
         cdf_min_q  <= '0;
         den_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         bit_cnt_q  <= '0;
         sat_q      <= 1'b0;
         pix_addr_q <= '0;
         cdf_addr_q <= '0;
         we_q       <= 1'b0;
         out_addr_q <= '0;
         out_bus_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         pix_idx_q  <= pix_idx_d;
         pix_q      <= pix_d;
         res_q      <= res_d;
         cdf_min_q  <= cdf_min_d;
         den_q      <= den_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         bit_cnt_q  <= bit_cnt_d;
         sat_q      <= sat_d;
         pix_addr_q <= pix_addr_d;
         cdf_addr_q <= cdf_addr_d;
         we_q       <= we_d;
         out_addr_q <= out_addr_d;
         out_bus_q  <= out_bus_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign mem.Pix_ReadAddress   = pix_addr_q;
   assign mem.Cdf_ReadAddress   = cdf_addr_q;
   assign mem.WriteEnable       = we_q;
   assign mem.Output_MEMAddress = out_addr_q;
   assign mem.Output_MEMBus     = out_bus_q;
   assign busy                  = busy_q;
   assign done                  = done_q;

endmodule

// File: doc/cdf_remap.md
CDF_REMAP -- requirements
Module: cdf_remap

Interface
- Parameters
  - REQ-001: Parameter PIX_BASE, default 16'h0000: scratchpad word address of the first input pixel word.
  - REQ-002: Parameter CDF_BASE, default 16'h4000: CDF memory word address of the CDF entry for pixel value 0.
  - REQ-003: Parameter OUT_BASE, default 16'h0000: output memory word address of the first remapped word.
  - REQ-004: Parameter NUM_WORDS, default 16384: number of 16-pixel words processed per run.
  - REQ-005: Parameter NUM_PIXELS, default 262144: total pixel count; this value is used as CDF max.
- Ports (one clock; reset is synchronous and active-low)
  - REQ-006: clock  in  1  single rising-edge clock.
  - REQ-007: reset_n  in  1  synchronous active-low reset.
  - REQ-008: start  in  1  single-cycle run request.
  - REQ-009: cdf_valid  in  1  CDF table and Cdf_Min are complete and stable.
  - REQ-010: Cdf_Min  in  20  minimum nonzero CDF value.
  - REQ-011: Pix_ReadAddress  out  16  pixel memory word address.
  - REQ-012: Pix_ReadBus  in  128  16 pixels; pixel k is in bits [8k+7:8k].
  - REQ-013: Cdf_ReadAddress  out  16  CDF memory word address.
  - REQ-014: Cdf_ReadBus  in  128  the CDF value is in bits [19:0]; all other bits are ignored.
  - REQ-015: WriteEnable  out  1  output memory write strobe.
  - REQ-016: Output_MEMAddress  out  16  output memory word address.
  - REQ-017: Output_MEMBus  out  128  16 remapped pixels, packed the same way as Pix_ReadBus.
  - REQ-018: busy  out  1  high in every state except IDLE.
  - REQ-019: done  out  1  one-cycle pulse at the end of a run.

Function
- Memory timing
  - REQ-020: Both read memories have 1-cycle latency: an address driven in cycle t gives valid data in cycle t+1.
- State machine (states IDLE, PIX_RD, PIX_WAIT, CDF_RD, CDF_WAIT, DIV, WRITE, DONE)
  - REQ-021: IDLE -> PIX_RD only when start=1 and cdf_valid=1; otherwise start is ignored.
  - REQ-022: PIX_RD: drive Pix_ReadAddress=PIX_BASE+word_idx, where word_idx is 0..NUM_WORDS-1.
  - REQ-023: PIX_WAIT: latch Pix_ReadBus into the pixel register; set pix_idx=0.
  - REQ-024: CDF_RD: drive Cdf_ReadAddress=CDF_BASE+{8'h00,pixel[pix_idx]}.
  - REQ-025: CDF_WAIT: latch Cdf_ReadBus[19:0]; form num=(cdf>Cdf_Min ? cdf-Cdf_Min : 0)*255 (28 bits) and den=NUM_PIXELS-Cdf_Min (20 bits).
  - REQ-026: DIV lasts exactly 8 cycles and is a restoring division producing quotient bits 7 down to 0.
  - REQ-027: In each DIV cycle, if rem >= den<<i then set q[i] and subtract den<<i.
  - REQ-028: The division truncates; there is no rounding.
  - REQ-029: If den==0, the result is 8'h00; DIV still takes 8 cycles.
  - REQ-030: If the quotient would exceed 255, the result saturates to 8'hFF.
  - REQ-031: After DIV, the result is stored in output byte pix_idx.
  - REQ-032: After DIV, if pix_idx<15: increment pix_idx and go to CDF_RD; otherwise go to WRITE.
  - REQ-033: WRITE: WriteEnable=1 for exactly one cycle, with Output_MEMAddress=OUT_BASE+word_idx and Output_MEMBus set to the packed word.
  - REQ-034: After WRITE, if word_idx<NUM_WORDS-1: increment word_idx and go to PIX_RD; otherwise go to DONE.
  - REQ-035: DONE: done=1 for one cycle, then go to IDLE.
  - REQ-036: Per-word cost is exactly 2 + 16*10 + 1 = 163 cycles.
  - REQ-037: A run takes 163*NUM_WORDS + 1 cycles from the cycle after start is accepted to the done pulse.
- Boundary conditions
  - REQ-038: start and cdf_valid are ignored whenever busy=1.
  - REQ-039: If cdf_valid deasserts mid-run, the run continues and the inputs are not resampled.
  - REQ-040: Cdf_Min is sampled once, at start acceptance; den is fixed for the whole run.
  - REQ-041: Address addition wraps modulo 2^16.
  - REQ-042: Read addresses hold their last value outside the read states.
  - REQ-043: WriteEnable is never asserted outside WRITE.

Reset
- REQ-044: When reset_n=0 at a rising edge, the following clear to 0 on that edge: state (to IDLE), word_idx, pix_idx, the pixel register, the result register, Pix_ReadAddress, Cdf_ReadAddress, WriteEnable, Output_MEMAddress, Output_MEMBus, busy and done.
- REQ-045: Reset mid-run aborts the run immediately; no further write and no done pulse follow.

Verification
- REQ-046: Reset: hold reset_n=0 for 2 cycles -> all outputs 0, busy=0.
- REQ-047: Ignored start: start=1 with cdf_valid=0 -> busy stays 0; no reads and no writes.
- REQ-048: Single word, divide path: NUM_WORDS=1, NUM_PIXELS=16, Cdf_Min=10, all pixels 8'h05, CDF[5]=16, CDF_BASE=16'h4000 -> 16 reads at 16'h4005; one write at OUT_BASE with all bytes 8'hFF; done exactly 164 cycles after start.
- REQ-049: Single word, mixed values: pixels 0..15 with CDF[v]=v+1, Cdf_Min=1, NUM_PIXELS=16 -> byte v = floor(v*255/15) = 17*v.
- REQ-050: Zero denominator: Cdf_Min=NUM_PIXELS=16 -> output word all 8'h00 with the same timing as REQ-048.
- REQ-051: Multi-word and reset abort: NUM_WORDS=3 -> writes at OUT_BASE, +1, +2 spaced 163 cycles apart; assert reset_n=0 during word 1 DIV -> no second write, no done, all outputs 0.
